// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command encodings, mode register fields and
// the power-up init sequencer state encoding.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    // Mode register fields: {reserved[11:10], wb[9], opmode[8:7], cl[6:4], bt[3], bl[2:0]}
    localparam logic [2:0] MR_BL_1      = 3'b000;
    localparam logic [2:0] MR_BL_2      = 3'b001;
    localparam logic [2:0] MR_BL_4      = 3'b010;
    localparam logic [2:0] MR_BL_8      = 3'b011;
    localparam logic       MR_BT_SEQ    = 1'b0;
    localparam logic       MR_BT_INTLV  = 1'b1;
    localparam logic [2:0] MR_CL_2      = 3'b010;
    localparam logic [2:0] MR_CL_3      = 3'b011;
    localparam logic       MR_WB_BURST  = 1'b0;
    localparam logic       MR_WB_SINGLE = 1'b1;
    localparam logic [11:0] MR_DEFAULT  =
        {2'b00, MR_WB_BURST, 2'b00, MR_CL_3, MR_BT_SEQ, MR_BL_4};

    typedef logic [2:0] state_t;
    localparam state_t ST_WAIT_PWR = 3'd0;
    localparam state_t ST_PRECH    = 3'd1;
    localparam state_t ST_WAIT_RP  = 3'd2;
    localparam state_t ST_REF      = 3'd3;
    localparam state_t ST_WAIT_RFC = 3'd4;
    localparam state_t ST_MRS      = 3'd5;
    localparam state_t ST_WAIT_MRD = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init.sv
// SDR SDRAM power-up init sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE, then sticky init_done. SDRAM_INIT_SIM_EN shortens the power-up wait to 20 cycles.
module sdram_init
    import sdram_pkg::*;
#(
    parameter int          T_POWERUP = 10000,
    parameter int          T_RP      = 2,
    parameter int          T_RFC     = 4,
    parameter int          REF_COUNT = 8,
    parameter int          T_MRD     = 2,
    parameter logic [11:0] MODE_REG  = 12'h032
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  cmd,
    output logic [11:0] addr,
    output logic [1:0]  ba,
    output logic        cke,
    output logic        init_done
);

`ifdef SDRAM_INIT_SIM_EN
    localparam int PWR_CYC = 20;
`else
    localparam int PWR_CYC = T_POWERUP;
`endif

    localparam int CNT_W = $clog2(max_int(max_int(T_POWERUP, PWR_CYC),
                                  max_int(T_RP, max_int(T_RFC, T_MRD))) + 1);
    localparam int RC_W  = $clog2(REF_COUNT + 1);

    // Each wait state covers the gap minus the one-cycle command state before it.
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] RFC_LAST = CNT_W'(T_RFC - 2);
    localparam logic [CNT_W-1:0] MRD_LAST = CNT_W'(T_MRD - 2);
    localparam logic [RC_W-1:0]  REF_N    = RC_W'(REF_COUNT);
    localparam logic [RC_W-1:0]  REF_LAST = RC_W'(REF_COUNT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [11:0]       addr_q, addr_d;
    logic [1:0]        ba_q, ba_d;
    logic              cke_q, cke_d;
    logic              done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        ref_cnt_d = ref_cnt_q;
        case (state_q)
            ST_WAIT_PWR: if (cnt_q == PWR_LAST) state_d = ST_PRECH;
            ST_PRECH:    state_d = (T_RP > 1) ? ST_WAIT_RP : ST_REF;
            ST_WAIT_RP:  if (cnt_q == RP_LAST) state_d = ST_REF;
            ST_REF: begin
                ref_cnt_d = ref_cnt_q + 1'b1;
                if (T_RFC > 1)
                    state_d = ST_WAIT_RFC;
                else
                    state_d = (ref_cnt_q == REF_LAST) ? ST_MRS : ST_REF;
            end
            ST_WAIT_RFC: if (cnt_q == RFC_LAST) state_d = (ref_cnt_q == REF_N) ? ST_MRS : ST_REF;
            ST_MRS:      state_d = (T_MRD > 1) ? ST_WAIT_MRD : ST_DONE;
            ST_WAIT_MRD: if (cnt_q == MRD_LAST) state_d = ST_DONE;
            ST_DONE:     cnt_d = cnt_q;
            default:     state_d = ST_WAIT_PWR;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Pins are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        cke_d  = 1'b1;
        done_d = (state_d == ST_DONE);
        case (state_d)
            ST_PRECH: begin
                cmd_d      = CMD_PRECHARGE;
                addr_d[10] = 1'b1;
            end
            ST_REF:  cmd_d = CMD_AREF;
            ST_MRS: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_PWR;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            ba_q      <= '0;
            cke_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            cke_q     <= cke_d;
            done_q    <= done_d;
        end
    end

    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign ba        = ba_q;
    assign cke       = cke_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// Directed bench for sdram_init: default-timing instance (20-cycle power-up) and
// an instance with REF_COUNT=2, T_RFC=7, MODE_REG=12'h023.
module tb_sdram_init;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic [3:0]  cmd_a, cmd_b;
    logic [11:0] addr_a, addr_b;
    logic [1:0]  ba_a, ba_b;
    logic        cke_a, cke_b, done_a, done_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [19:0] RST_VEC = {4'b0111, 12'h000, 2'b00, 1'b0, 1'b0};

    always #5 clk = ~clk;

    sdram_init #(.T_POWERUP(20)) u_a (
        .clk(clk), .rst(rst), .cmd(cmd_a), .addr(addr_a), .ba(ba_a),
        .cke(cke_a), .init_done(done_a)
    );

    sdram_init #(.T_POWERUP(20), .REF_COUNT(2), .T_RFC(7), .MODE_REG(12'h023)) u_b (
        .clk(clk), .rst(rst2), .cmd(cmd_b), .addr(addr_b), .ba(ba_b),
        .cke(cke_b), .init_done(done_b)
    );

    wire [19:0] obs_a = {cmd_a, addr_a, ba_a, cke_a, done_a};
    wire [19:0] obs_b = {cmd_b, addr_b, ba_b, cke_b, done_b};

    // Expected pins during cycle c, from the datasheet-style schedule (P=20, T_RP=2, T_MRD=2).
    function automatic logic [19:0] exp_vec(input int c, input int nref, input int trfc,
                                            input logic [11:0] mreg);
        int p = 20;
        int m;
        logic [3:0]  cm = 4'b0111;
        logic [11:0] ad = 12'h000;
        m = p + 2 + nref * trfc;
        if (c == p) begin
            cm = 4'b0010;
            ad = 12'h400;
        end else if (c == m) begin
            cm = 4'b0000;
            ad = mreg;
        end else if (c >= p + 2 && c < m && ((c - p - 2) % trfc) == 0) begin
            cm = 4'b0001;
        end
        return {cm, ad, 2'b00, (c >= 1), (c >= m + 2)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_a !== RST_VEC) begin
            errors++;
            $display("FAIL reset_a: got %h want %h", obs_a, RST_VEC);
        end
        checks++;
        if (obs_b !== RST_VEC) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", obs_b, RST_VEC);
        end
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (obs_a !== exp_vec(0, 8, 4, 12'h032)) begin
            errors++;
            $display("FAIL cycle0_a: got %h want %h", obs_a, exp_vec(0, 8, 4, 12'h032));
        end
    endtask

    task automatic test_powerup();
        while (cyc < 20) begin
            step();
            checks++;
            if (obs_a !== exp_vec(cyc, 8, 4, 12'h032)) begin
                errors++;
                $display("FAIL powerup cyc %0d: got %h want %h", cyc, obs_a, exp_vec(cyc, 8, 4, 12'h032));
            end
        end
    endtask

    task automatic test_full_sequence();
        int nref = 0;
        while (cyc < 60) begin
            step();
            if (cmd_a === 4'b0001) nref++;
            checks++;
            if (obs_a !== exp_vec(cyc, 8, 4, 12'h032)) begin
                errors++;
                $display("FAIL sequence cyc %0d: got %h want %h", cyc, obs_a, exp_vec(cyc, 8, 4, 12'h032));
            end
        end
        checks++;
        if (nref != 8) begin
            errors++;
            $display("FAIL refresh_count: got %0d want 8", nref);
        end
    endtask

    task automatic test_hold_done();
        repeat (200) begin
            step();
            checks++;
            if (cmd_a !== 4'b0111 || done_a !== 1'b1) begin
                errors++;
                $display("FAIL hold_done cyc %0d: cmd %b done %b want 0111 1", cyc, cmd_a, done_a);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nref = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (cyc < 37) step();
        checks++;
        if (obs_a !== exp_vec(37, 8, 4, 12'h032)) begin
            errors++;
            $display("FAIL pre_abort cyc 37: got %h want %h", obs_a, exp_vec(37, 8, 4, 12'h032));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs_a !== RST_VEC) begin
            errors++;
            $display("FAIL abort_async: got %h want %h", obs_a, RST_VEC);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (obs_a !== exp_vec(0, 8, 4, 12'h032)) begin
            errors++;
            $display("FAIL restart cyc 0: got %h want %h", obs_a, exp_vec(0, 8, 4, 12'h032));
        end
        while (cyc < 60) begin
            step();
            if (cmd_a === 4'b0001) nref++;
            checks++;
            if (obs_a !== exp_vec(cyc, 8, 4, 12'h032)) begin
                errors++;
                $display("FAIL restart cyc %0d: got %h want %h", cyc, obs_a, exp_vec(cyc, 8, 4, 12'h032));
            end
        end
        checks++;
        if (nref != 8) begin
            errors++;
            $display("FAIL restart_refresh_count: got %0d want 8", nref);
        end
    endtask

    task automatic test_override();
        int nref = 0;
        @(negedge clk);
        checks++;
        if (obs_b !== RST_VEC) begin
            errors++;
            $display("FAIL override_reset: got %h want %h", obs_b, RST_VEC);
        end
        rst2 = 1'b0;
        cyc = 0;
        while (cyc < 45) begin
            step();
            if (cmd_b === 4'b0001) nref++;
            checks++;
            if (obs_b !== exp_vec(cyc, 2, 7, 12'h023)) begin
                errors++;
                $display("FAIL override cyc %0d: got %h want %h", cyc, obs_b, exp_vec(cyc, 2, 7, 12'h023));
            end
        end
        checks++;
        if (nref != 2) begin
            errors++;
            $display("FAIL override_refresh_count: got %0d want 2", nref);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_full_sequence();
        test_hold_done();
        test_mid_reset();
        test_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
